jtag_host_driver: RTL

//  Upstream stimulus stage for the jtag top: converts command transactions into

---
 rtl/jtag_host_driver.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/jtag_host_driver.sv
// JTAG host driver: turns TAP reset / IR scan / DR scan commands into
// TCK/TMS/TDI pin activity and gathers TDO into a response word.
module jtag_host_driver #(
   parameter int MAX_LEN  = 16,
   parameter int LEN_W    = $clog2(MAX_LEN + 1),
   parameter int TCK_HALF = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [LEN_W-1:0]   cmd_len,
   input  logic [MAX_LEN-1:0] cmd_data,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [MAX_LEN-1:0] rsp_data,
   output logic               busy,
   output logic               TCK,
   output logic               TMS,
   output logic               TDI,
   input  logic               TDO
);

   localparam int SLOT_W = LEN_W + 3;
   localparam int PH_W   = $clog2(2 * TCK_HALF);
   localparam int IDX_W  = $clog2(MAX_LEN);

   localparam logic [PH_W-1:0] PH_HI  = PH_W'(TCK_HALF);
   localparam logic [PH_W-1:0] PH_END = PH_W'(2 * TCK_HALF - 1);

   localparam logic [1:0] OP_NOP = 2'd0;
   localparam logic [1:0] OP_RST = 2'd1;
   localparam logic [1:0] OP_IR  = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_SHIFT,
      S_POST,
      S_RESP
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic [1:0]         op_q;
   logic [LEN_W-1:0]   len_q;
   logic [MAX_LEN-1:0] data_q;
   logic [MAX_LEN-1:0] rsp_q;
   logic [PH_W-1:0]    phase_q;
   logic [SLOT_W-1:0]  slot_q;
   logic               null_q;
   logic               tms_idle_q;

   logic               accept;
   logic               run;
   logic               slot_end;
   logic               shift_last;
   logic               post_last;
   logic [SLOT_W-1:0]  pre_last;
   logic [LEN_W-1:0]   len_clamp;
   logic               null_d;
   logic               tms_seq;
   logic [IDX_W-1:0]   idx;

   assign cmd_ready = (state_q == S_IDLE) && !rst;
   assign accept    = cmd_valid && cmd_ready;
   assign run       = (state_q inside {S_PRE, S_SHIFT, S_POST}) && !null_q;
   assign slot_end  = run && (phase_q == PH_END);
   assign idx       = slot_q[IDX_W-1:0];

   assign len_clamp = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
   assign null_d    = (cmd_op == OP_NOP) ||
                      ((cmd_op != OP_RST) && (len_clamp == '0));

   assign shift_last = ((slot_q + SLOT_W'(1)) == SLOT_W'(len_q));
   assign post_last  = (slot_q == SLOT_W'(1));

   // last preamble slot index for the latched opcode
   always_comb begin
      pre_last = SLOT_W'(2);
      unique case (op_q)
         OP_RST:  pre_last = SLOT_W'(5);
         OP_IR:   pre_last = SLOT_W'(3);
         default: pre_last = SLOT_W'(2);
      endcase
   end

   // TMS value for the current slot of the walk through the TAP FSM
   always_comb begin
      tms_seq = 1'b0;
      unique case (state_q)
         S_PRE: begin
            unique case (op_q)
               OP_RST:  tms_seq = (slot_q < SLOT_W'(5));
               OP_IR:   tms_seq = (slot_q < SLOT_W'(2));
               default: tms_seq = (slot_q == '0);
            endcase
         end
         S_SHIFT: tms_seq = shift_last;
         S_POST:  tms_seq = (slot_q == '0);
         default: tms_seq = 1'b0;
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // next-state decode
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (accept) state_d = S_PRE;
         S_PRE: begin
            if (null_q)
               state_d = S_RESP;
            else if (slot_end && (slot_q == pre_last))
               state_d = (op_q == OP_RST) ? S_RESP : S_SHIFT;
         end
         S_SHIFT: if (slot_end && shift_last) state_d = S_POST;
         S_POST:  if (slot_end && post_last) state_d = S_RESP;
         S_RESP:  if (rsp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // command latch, bit-slot timing and TDO capture
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q       <= OP_NOP;
         len_q      <= '0;
         data_q     <= '0;
         rsp_q      <= '0;
         phase_q    <= '0;
         slot_q     <= '0;
         null_q     <= 1'b0;
         tms_idle_q <= 1'b1;
      end else if (accept) begin
         op_q       <= cmd_op;
         len_q      <= len_clamp;
         data_q     <= cmd_data;
         rsp_q      <= '0;
         phase_q    <= '0;
         slot_q     <= '0;
         null_q     <= null_d;
         tms_idle_q <= 1'b0;
      end else if (run) begin
         phase_q <= slot_end ? '0 : phase_q + PH_W'(1);
         if (slot_end) begin
            slot_q <= (state_d != state_q) ? '0 : slot_q + SLOT_W'(1);
            if (state_q == S_SHIFT) rsp_q[idx] <= TDO;
         end
      end
   end

   assign TCK       = run && (phase_q >= PH_HI);
   assign TMS       = run ? tms_seq : tms_idle_q;
   assign TDI       = (state_q == S_SHIFT) && !null_q && data_q[idx];
   assign rsp_valid = (state_q == S_RESP);
   assign rsp_data  = rsp_q;
   assign busy      = (state_q != S_IDLE);

endmodule
